cra_adder_reg: RTL and testbench

- Parameterised ripple-carry adder (CRA): a chain of n 1-bit full-adder cells, carry rippling from bit 0 to bit n-1.
- Result and carry-out are captured in an output register with a valid flag: one-cycle-latency arithmetic leaf.
- Serves as the design-under-test slot for the adder comparison and switching-activity flow, and as a reusable datapath adder.
- Architecture must stay a true bit-serial carry chain: no lookahead, no carry-select, no `+` operator in the core.

---
 rtl/cra_adder_reg_pkg.sv | 5 +
 rtl/cra_adder_reg_if.sv | 35 +++
 rtl/cra_adder_reg_full_adder_cell.sv | 15 +
 rtl/cra_adder_reg.sv | 48 ++++
 tb/tb_cra_adder_reg.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/cra_adder_reg_pkg.sv
// Shared constants for the ripple-carry adder leaf.
// Only the default operand width lives here.
package cra_adder_reg_pkg;
  localparam int ADDER_WIDTH = 128;
endpackage

// File: rtl/cra_adder_reg_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// master drives operands, slave returns the registered result.
interface cra_adder_reg_if
  import cra_adder_reg_pkg::*;
#(
  parameter int N = ADDER_WIDTH
);
  logic         in_valid;
  logic         cin;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic [N-1:0] s;
  logic         cout;

  modport master (
    output in_valid,
    output cin,
    output a,
    output b,
    input  out_valid,
    input  s,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  cin,
    input  a,
    input  b,
    output out_valid,
    output s,
    output cout
  );
endinterface

// File: rtl/cra_adder_reg_full_adder_cell.sv
// One-bit full adder: the repeated cell of the carry chain.
// Carry is generate OR (propagate AND carry-in).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/cra_adder_reg.sv
// Parameterised ripple-carry adder with a registered result.
// One-cycle latency, one operation per cycle, no backpressure.
module cra_adder_reg
  import cra_adder_reg_pkg::*;
#(
  parameter int n = ADDER_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  cra_adder_reg_if.slave bus
);
  logic [n:0]   w_c;
  logic [n-1:0] w_sum;
  logic [n-1:0] r_s;
  logic         r_cout;
  logic         r_valid;

  assign w_c[0] = bus.cin;

  // Carry ripples strictly from bit 0 upward.
  for (genvar i = 0; i < n; i++) begin : g_chain
    full_adder_cell u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (w_c[i]),
      .s  (w_sum[i]),
      .co (w_c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s    <= w_sum;
        r_cout <= w_c[n];
      end
    end
  end

  assign bus.s         = r_s;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_cra_adder_reg.sv
// Directed plus random checks of cra_adder_reg
// against an arithmetic reference model.
module tb_cra_adder_reg;
  import cra_adder_reg_pkg::*;

  localparam int N = ADDER_WIDTH;
  localparam int W = N + 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cra_adder_reg_if #(.N(N)) bus ();

  cra_adder_reg #(.n(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] exp_r;
  logic         exp_v;
  logic [N-1:0] pa;
  logic [N-1:0] pb;
  logic         pc;
  logic [N-1:0] ones;

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < (N + 31) / 32; k++)
      v = (v << 32) | N'($urandom);
    return v;
  endfunction

  task automatic chk(string tag,
                     logic [W-1:0] obs,
                     logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s obs=%h exp=%h a=%h b=%h cin=%0d",
             tag, obs, exp, pa, pb, pc);
    end
  endtask

  task automatic drive(logic v, logic [N-1:0] a,
                       logic [N-1:0] b, logic c);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
  endtask

  // Reference: {cout, s} = a + b + cin at every accepted edge.
  task automatic tick(string tag);
    @(posedge clk);
    if (!rst_n) begin
      exp_r = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = bus.in_valid;
      if (bus.in_valid) begin
        pa    = bus.a;
        pb    = bus.b;
        pc    = bus.cin;
        exp_r = W'(pa) + W'(pb) + W'(pc);
      end
    end
    #1;
    chk({tag, ".sum"}, {bus.cout, bus.s}, exp_r);
    chk({tag, ".vld"}, W'(bus.out_valid), W'(exp_v));
  endtask

  initial begin
    ones  = '1;
    exp_r = '0;
    exp_v = 1'b0;
    pa    = '0;
    pb    = '0;
    pc    = 1'b0;
    rst_n = 1'b0;
    drive(1'b1, rnd(), rnd(), 1'b1);
    #1;
    chk("rst0.sum", {bus.cout, bus.s}, '0);
    chk("rst0.vld", W'(bus.out_valid), '0);

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, rnd(), rnd(), k[0]);
      tick("rst");
    end

    rst_n = 1'b1;
    drive(1'b0, rnd(), rnd(), 1'b0);
    tick("idle");
    tick("idle");
    chk("idle.zero", {bus.cout, bus.s}, '0);

    drive(1'b1, N'(5), N'(3), 1'b0);
    tick("add53");
    chk("add53.k", {bus.cout, bus.s}, W'(8));
    drive(1'b1, N'(5), N'(3), 1'b1);
    tick("add53c");
    chk("add53c.k", {bus.cout, bus.s}, W'(9));

    drive(1'b1, ones, '0, 1'b1);
    tick("ripple");
    chk("ripple.k", {bus.cout, bus.s}, W'(1) << N);
    drive(1'b1, ones, ones, 1'b1);
    tick("maxmax");
    chk("maxmax.k", {bus.cout, bus.s}, {1'b1, ones});

    drive(1'b1, N'('h1234), N'(1), 1'b0);
    tick("hold0");
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, rnd(), rnd(), 1'b1);
      if (k == 1) begin
        bus.a = 'x;
        bus.b = 'x;
      end
      tick("hold");
      chk("hold.k", {bus.cout, bus.s}, W'('h1235));
    end

    for (int k = 0; k < 30000; k++) begin
      drive(1'b1, rnd(), rnd(), 1'($urandom));
      tick("rand");
    end

    drive(1'b1, rnd(), rnd(), 1'b0);
    tick("mid0");
    drive(1'b1, rnd(), rnd(), 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_r = '0;
    exp_v = 1'b0;
    chk("arst.sum", {bus.cout, bus.s}, '0);
    chk("arst.vld", W'(bus.out_valid), '0);
    tick("inrst");
    rst_n = 1'b1;
    drive(1'b1, rnd(), rnd(), 1'b1);
    tick("post");
    drive(1'b0, rnd(), rnd(), 1'b0);
    tick("post.idle");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
